// File: rtl/axis_rr_arb_mux.sv
// axis_rr_arb_mux: round-robin, packet-granular AXI-Stream multiplexer.
// One input port holds the grant from the first accepted beat until its
// tlast beat is accepted. Beats pass through a two-entry skid buffer
// (output register plus temp register). Because of the skid buffer, the
// input tready depends only on registered state.
module axis_rr_arb_mux #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [PORTS*DATA_WIDTH-1:0]   input_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   input_axis_tkeep,
    input  logic [PORTS-1:0]              input_axis_tvalid,
    output logic [PORTS-1:0]              input_axis_tready,
    input  logic [PORTS-1:0]              input_axis_tlast,
    input  logic [PORTS-1:0]              input_axis_tuser,
    output logic [DATA_WIDTH-1:0]         output_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
    output logic                          output_axis_tvalid,
    input  logic                          output_axis_tready,
    output logic                          output_axis_tlast,
    output logic                          output_axis_tuser,
    output logic                          grant_valid,
    output logic [$clog2(PORTS)-1:0]      grant_encoded
);

    localparam int IDX_W = $clog2(PORTS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Arbitration state
    logic [0:0]            r_state;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_last_grant;

    // Skid buffer: output register and temp register
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_WIDTH-1:0] r_out_keep;
    logic                  r_out_last;
    logic                  r_out_user;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_tmp_data;
    logic [KEEP_WIDTH-1:0] r_tmp_keep;
    logic                  r_tmp_last;
    logic                  r_tmp_user;
    logic                  r_tmp_valid;

    // Combinational helpers
    logic [PORTS-1:0]      w_tready;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [KEEP_WIDTH-1:0] w_sel_keep;
    logic                  w_sel_last;
    logic                  w_sel_user;
    logic                  w_accept;
    logic                  w_out_hs;
    logic                  w_pick_found;
    logic [IDX_W-1:0]      w_pick;
    int                    w_idx;

    // tready depends only on the state, the grant and the temp occupancy.
    // Keeping the temp register empty guarantees room for an accepted beat.
    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_tready
            assign w_tready[gi] = (r_state == ST_ACTIVE) &&
                                  (r_grant == IDX_W'(gi)) &&
                                  !r_tmp_valid;
        end
    endgenerate

    // Select the granted port's sideband. The grant is always below PORTS,
    // so the index is always in range.
    assign w_sel_data = input_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_keep = input_axis_tkeep[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
    assign w_sel_last = input_axis_tlast[r_grant];
    assign w_sel_user = input_axis_tuser[r_grant];
    assign w_accept   = w_tready[r_grant] && input_axis_tvalid[r_grant];
    assign w_out_hs   = r_out_valid && output_axis_tready;

    // Round-robin search: find the first valid port after the last grant,
    // wrapping around.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_idx        = 0;
        for (int k = 1; k <= PORTS; k++) begin
            w_idx = (int'(r_last_grant) + k) % PORTS;
            if (!w_pick_found && input_axis_tvalid[w_idx]) begin
                w_pick_found = 1'b1;
                w_pick       = IDX_W'(w_idx);
            end
        end
    end

    // Grant FSM. A new grant is taken only from IDLE. The grant is released
    // only by the accepted tlast beat, so enable cannot cut a packet short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(PORTS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_pick_found) begin
                        r_state      <= ST_ACTIVE;
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                    end
                end
                default: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Skid buffer. An accepted beat goes to the output register when that
    // register can take it this cycle; otherwise it goes to temp. Temp
    // refills the output register on the next handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
            r_out_valid <= 1'b0;
            r_tmp_data  <= '0;
            r_tmp_keep  <= '0;
            r_tmp_last  <= 1'b0;
            r_tmp_user  <= 1'b0;
            r_tmp_valid <= 1'b0;
        end else if (w_accept) begin
            if (!r_out_valid || output_axis_tready) begin
                r_out_data  <= w_sel_data;
                r_out_keep  <= w_sel_keep;
                r_out_last  <= w_sel_last;
                r_out_user  <= w_sel_user;
                r_out_valid <= 1'b1;
            end else begin
                r_tmp_data  <= w_sel_data;
                r_tmp_keep  <= w_sel_keep;
                r_tmp_last  <= w_sel_last;
                r_tmp_user  <= w_sel_user;
                r_tmp_valid <= 1'b1;
            end
        end else if (w_out_hs) begin
            if (r_tmp_valid) begin
                r_out_data  <= r_tmp_data;
                r_out_keep  <= r_tmp_keep;
                r_out_last  <= r_tmp_last;
                r_out_user  <= r_tmp_user;
                r_tmp_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // All outputs read as zero while reset is held, even in the cycle
    // before the reset edge lands.
    assign input_axis_tready  = rst_n ? w_tready : '0;
    assign output_axis_tdata  = rst_n ? r_out_data : '0;
    assign output_axis_tkeep  = rst_n ? r_out_keep : '0;
    assign output_axis_tvalid = rst_n && r_out_valid;
    assign output_axis_tlast  = rst_n && r_out_last;
    assign output_axis_tuser  = rst_n && r_out_user;
    assign grant_valid        = rst_n && (r_state == ST_ACTIVE);
    assign grant_encoded      = rst_n ? r_grant : '0;

endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// Directed scoreboard testbench for axis_rr_arb_mux (4 ports, 8-bit data).
module tb_axis_rr_arb_mux;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int KW    = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [PORTS*DW-1:0]   in_tdata;
    logic [PORTS*KW-1:0]   in_tkeep;
    logic [PORTS-1:0]      in_tvalid;
    logic [PORTS-1:0]      in_tready;
    logic [PORTS-1:0]      in_tlast;
    logic [PORTS-1:0]      in_tuser;
    logic [DW-1:0]         out_tdata;
    logic [KW-1:0]         out_tkeep;
    logic                  out_tvalid;
    logic                  out_tready;
    logic                  out_tlast;
    logic                  out_tuser;
    logic                  gnt_valid;
    logic [1:0]            gnt_enc;

    axis_rr_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .input_axis_tdata   (in_tdata),
        .input_axis_tkeep   (in_tkeep),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tready  (in_tready),
        .input_axis_tlast   (in_tlast),
        .input_axis_tuser   (in_tuser),
        .output_axis_tdata  (out_tdata),
        .output_axis_tkeep  (out_tkeep),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tready (out_tready),
        .output_axis_tlast  (out_tlast),
        .output_axis_tuser  (out_tuser),
        .grant_valid        (gnt_valid),
        .grant_encoded      (gnt_enc)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t src_q[PORTS][$];
    beat_t exp_q[$];
    logic [PORTS-1:0] hs;
    logic [PORTS-1:0] obs_tready;
    logic  obs_gv;
    logic [1:0] obs_ge;
    logic  obs_ovalid;
    logic  prev_stall = 1'b0;
    beat_t prev_out;
    int    order[6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic u, input logic k);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.user = u;
        return b;
    endfunction

    // Queue a beat on a port; when exp is set, also record it as expected output.
    task automatic load(input int p, input beat_t b, input bit expect_out);
        src_q[p].push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int p = 0; p < PORTS; p++) begin
            if (src_q[p].size() > 0) begin
                b = src_q[p][0];
                in_tvalid[p] = 1'b1;
                in_tdata[p*DW +: DW] = b.data;
                in_tkeep[p*KW +: KW] = b.keep;
                in_tlast[p] = b.last;
                in_tuser[p] = b.user;
            end else begin
                in_tvalid[p] = 1'b0;
                in_tdata[p*DW +: DW] = '0;
                in_tkeep[p*KW +: KW] = '0;
                in_tlast[p] = 1'b0;
                in_tuser[p] = 1'b0;
            end
        end
    endtask

    // One clock: drive, sample/score on the falling edge, retire accepted inputs.
    task automatic tick();
        beat_t got;
        beat_t e;
        drive_inputs();
        @(negedge clk);
        cyc++;
        obs_tready = in_tready;
        obs_gv     = gnt_valid;
        obs_ge     = gnt_enc;
        obs_ovalid = out_tvalid;
        hs         = in_tvalid & in_tready;
        got.data = out_tdata; got.keep = out_tkeep; got.last = out_tlast; got.user = out_tuser;
        if (rst_n && prev_stall) begin
            check("stall_valid", {31'd0, out_tvalid}, 32'd1);
            check("stall_beat", {13'd0, got}, {13'd0, prev_out});
        end
        if (out_tvalid && out_tready) begin
            check("exp_avail", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_beat", {13'd0, got}, {13'd0, e});
                $display("cycle %0d: out data=%02h keep=%0h last=%0b user=%0b", cyc, got.data, got.keep, got.last, got.user);
            end
        end
        prev_stall = rst_n && out_tvalid && !out_tready;
        prev_out   = got;
        @(posedge clk);
        #1;
        for (int p = 0; p < PORTS; p++)
            if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    endtask

    task automatic drain(input string tag);
        int n = 0;
        out_tready = 1'b1;
        enable = 1'b1;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
                src_q[2].size() != 0 || src_q[3].size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check({"drain_", tag}, exp_q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int p = 0; p < PORTS; p++) src_q[p].delete();
        exp_q.delete();
        repeat (n) tick();
        check("rst_tready", {28'd0, obs_tready}, 32'd0);
        check("rst_ovalid", {31'd0, obs_ovalid}, 32'd0);
        check("rst_gv", {31'd0, obs_gv}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; out_tready = 1'b1;
        in_tdata = '0; in_tkeep = '0; in_tvalid = '0; in_tlast = '0; in_tuser = '0;
        @(posedge clk); #1;

        // Reset state
        do_reset(3);
        check("rst_ge", {30'd0, obs_ge}, 32'd0);
        tick();
        check("post_rst_gv", {31'd0, obs_gv}, 32'd0);
        check("post_rst_tready", {28'd0, obs_tready}, 32'd0);

        // Single 3-beat packet on port 2
        load(2, mk(8'hA1, 1'b0, 1'b0, 1'b1), 1);
        load(2, mk(8'hA2, 1'b0, 1'b1, 1'b1), 1);
        load(2, mk(8'hA3, 1'b1, 1'b0, 1'b1), 1);
        tick();
        check("t1_idle_gv", {31'd0, obs_gv}, 32'd0);
        tick();
        check("t1_gv", {31'd0, obs_gv}, 32'd1);
        check("t1_ge", {30'd0, obs_ge}, 32'd2);
        check("t1_tready", {28'd0, obs_tready}, 32'b0100);
        check("t1_lat_ovalid0", {31'd0, obs_ovalid}, 32'd0);
        tick();
        check("t1_ovalid_b1", {31'd0, obs_ovalid}, 32'd1);
        tick();
        check("t1_ovalid_b2", {31'd0, obs_ovalid}, 32'd1);
        tick();
        check("t1_ovalid_b3", {31'd0, obs_ovalid}, 32'd1);
        check("t1_release_gv", {31'd0, obs_gv}, 32'd0);
        drain("single");

        // Fairness: all ports valid, 1-beat packets
        do_reset(1);
        load(0, mk(8'h10, 1'b1, 1'b0, 1'b1), 1);
        load(1, mk(8'h11, 1'b1, 1'b0, 1'b1), 1);
        load(2, mk(8'h12, 1'b1, 1'b0, 1'b1), 1);
        load(3, mk(8'h13, 1'b1, 1'b0, 1'b1), 1);
        load(0, mk(8'h20, 1'b1, 1'b1, 1'b1), 1);
        load(1, mk(8'h21, 1'b1, 1'b0, 1'b1), 1);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("fair_gv", {31'd0, obs_gv}, k % 2);
            if (k % 2 == 1) begin
                check("fair_ge", {30'd0, obs_ge}, order[k/2]);
                $display("cycle %0d: grant port %0d", cyc, obs_ge);
            end
        end
        drain("fair");

        // Backpressure during a 4-beat packet on port 0
        load(0, mk(8'hB1, 1'b0, 1'b0, 1'b1), 1);
        load(0, mk(8'hB2, 1'b0, 1'b1, 1'b0), 1);
        load(0, mk(8'hB3, 1'b0, 1'b0, 1'b1), 1);
        load(0, mk(8'hB4, 1'b1, 1'b0, 1'b1), 1);
        out_tready = 1'b1; tick();
        out_tready = 1'b1; tick();
        out_tready = 1'b1; tick();
        out_tready = 1'b0; tick();
        check("bp_tready_still", {28'd0, obs_tready}, 32'b0001);
        out_tready = 1'b0; tick();
        check("bp_tready_drop", {28'd0, obs_tready}, 32'd0);
        out_tready = 1'b1; tick();
        check("bp_tready_held", {28'd0, obs_tready}, 32'd0);
        out_tready = 1'b1; tick();
        check("bp_tready_back", {28'd0, obs_tready}, 32'b0001);
        drain("backpressure");

        // Enable gating mid-packet on port 1
        load(1, mk(8'hC1, 1'b0, 1'b0, 1'b1), 1);
        load(1, mk(8'hC2, 1'b0, 1'b0, 1'b1), 1);
        load(1, mk(8'hC3, 1'b1, 1'b0, 1'b1), 1);
        tick();
        tick();
        check("en_ge", {30'd0, obs_ge}, 32'd1);
        enable = 1'b0;
        tick();
        load(3, mk(8'hD1, 1'b1, 1'b1, 1'b1), 1);
        tick();
        check("en_active_gv", {31'd0, obs_gv}, 32'd1);
        check("en_active_ge", {30'd0, obs_ge}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("en_off_gv", {31'd0, obs_gv}, 32'd0);
            check("en_off_tready", {28'd0, obs_tready}, 32'd0);
        end
        enable = 1'b1;
        tick();
        check("en_on_idle", {31'd0, obs_gv}, 32'd0);
        tick();
        check("en_on_gv", {31'd0, obs_gv}, 32'd1);
        check("en_on_ge", {30'd0, obs_ge}, 32'd3);
        drain("enable");

        // Reset during beat 2 of a port-1 packet
        load(1, mk(8'hE1, 1'b0, 1'b0, 1'b1), 0);
        load(1, mk(8'hE2, 1'b0, 1'b0, 1'b1), 0);
        load(1, mk(8'hE3, 1'b0, 1'b0, 1'b1), 0);
        load(1, mk(8'hE4, 1'b1, 1'b0, 1'b1), 0);
        tick();
        tick();
        check("mr_ge", {30'd0, obs_ge}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("mr_ovalid", {31'd0, obs_ovalid}, 32'd0);
        check("mr_tready", {28'd0, obs_tready}, 32'd0);
        check("mr_gv", {31'd0, obs_gv}, 32'd0);
        rst_n = 1'b1;
        for (int p = 0; p < PORTS; p++) src_q[p].delete();
        exp_q.delete();
        load(0, mk(8'h60, 1'b1, 1'b0, 1'b1), 1);
        load(1, mk(8'h61, 1'b1, 1'b0, 1'b1), 1);
        tick();
        tick();
        check("mr_regrant_gv", {31'd0, obs_gv}, 32'd1);
        check("mr_regrant_ge", {30'd0, obs_ge}, 32'd0);
        drain("reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
